// File: rtl/rr_stream_mux.sv
// ---------------------------------------------------------------------------
// rr_stream_mux
//
// Round-robin multiplexer of 2**N valid/ready streams onto one registered
// output stream. One output register stage; a beat can drain and a new one
// load in the same cycle, so sustained throughput is one beat per cycle.
//
// Optional feature (compile-time macro RR_STREAM_MUX_PKT_LOCK_EN):
//   When defined, a channel that starts a packet (beat with in_last=0) keeps
//   the grant until it delivers its in_last=1 beat. When undefined, no lock
//   state exists and every beat is arbitrated independently.
//
// Parameters:
//   WIDTH  payload bits per channel
//   N      select width, NCH = 2**N channels
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    per-channel payload (unpacked [NCH])
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered payload
//   out_sel    channel index the current out_data came from
//   out_last   registered in_last of the accepted beat
//   out_valid  output valid
//   out_ready  downstream ready
// ---------------------------------------------------------------------------
module rr_stream_mux #(
  parameter int WIDTH = 32,
  parameter int N = 2,
  localparam int NCH = 2**N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data [NCH],
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH-1:0]   in_last,
  output logic [NCH-1:0]   in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [N-1:0]     out_sel,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  // ptr holds the most recently granted channel; the search starts just
  // after it, which is what makes the arbitration round-robin.
  logic [N-1:0] ptr;
  logic [N-1:0] grant;
  logic [N-1:0] cand;
  logic         any_valid;
  logic         offer;
  logic         load;
  logic         xfer;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic         lock;
  logic [N-1:0] lock_ch;
`endif

  // The output slot can accept a new beat when empty or when its current
  // beat leaves this cycle.
  assign load = !out_valid || out_ready;

  // Search ptr+1, ptr+2, ..., ptr (N-bit wrap). The last candidate is ptr
  // itself, so a lone valid channel is always found.
  always_comb begin
    grant     = ptr;
    cand      = ptr;
    any_valid = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = ptr + N'(i);
      if (!any_valid && in_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    // A packet in progress owns the output even while its source is idle.
    if (lock) begin
      grant     = lock_ch;
      any_valid = in_valid[lock_ch];
    end
`endif
  end

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  // The locked channel is offered ready whenever the slot is free, whether
  // or not it is currently presenting a beat.
  assign offer = any_valid || lock;
`else
  assign offer = any_valid;
`endif

  assign xfer = load && any_valid;

  always_comb begin
    in_ready = '0;
    if (load && offer) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register stage and arbitration state. Reset wins over any
  // pending or held beat, which is simply discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      ptr       <= '1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock      <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant];
        out_sel   <= grant;
        out_last  <= in_last[grant];
        ptr       <= grant;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        lock      <= !in_last[grant];
        lock_ch   <= grant;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_stream_mux
//
// Bench for rr_stream_mux with WIDTH=8, N=2 (four channels). A behavioural
// arbiter model predicts in_ready and pushes every accepted beat into a
// scoreboard queue; beats are compared while held and popped when drained.
// A table of hand-derived vectors adds explicit in_ready / out_sel
// expectations, followed by a randomised run checked by the model alone.
// Build with +define+RR_STREAM_MUX_PKT_LOCK_EN to exercise packet lock.
// ---------------------------------------------------------------------------
module tb_rr_stream_mux;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data [4];
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  rr_stream_mux #(.WIDTH(8), .N(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       r;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] sel;
    logic [7:0] d1;
    logic [7:0] d2;
    bit         rst;
  } vec_t;

  beat_t sb [$];
  vec_t  vecs [$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_valid;
  logic [1:0] m_ptr;
  logic       m_lock;
  logic [1:0] m_lock_ch;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [3:0] v, input logic [3:0] l, input logic r,
                         input logic [3:0] rdy, input logic ov, input logic [1:0] sel,
                         input logic [7:0] d1, input logic [7:0] d2, input bit rst);
    vec_t e;
    e.v = v; e.l = l; e.r = r; e.rdy = rdy; e.ov = ov; e.sel = sel;
    e.d1 = d1; e.d2 = d2; e.rst = rst;
    vecs.push_back(e);
  endtask

  // Reset with the given inputs applied; everything in flight is dropped.
  task automatic do_reset(input logic [3:0] v, input logic r);
    in_valid  = v;
    out_ready = r;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_sel", out_sel, 0);
    check_output("rst_out_last", out_last, 0);
    m_valid   = 1'b0;
    m_ptr     = 2'd3;
    m_lock    = 1'b0;
    m_lock_ch = 2'd0;
    sb.delete();
    rst_n     = 1'b1;
  endtask

  // One clock cycle: drive, predict and check the handshake, update the
  // model and scoreboard, then check out_valid after the edge.
  task automatic apply_stimulus(input logic [3:0] v, input logic [3:0] l, input logic r,
                                input bit tab, input logic [3:0] t_rdy,
                                input logic t_ov, input logic [1:0] t_sel);
    logic       load;
    logic       any;
    logic [1:0] g;
    logic [1:0] idx;
    logic [3:0] rdy_m;
    beat_t      b;
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    #1;
    load = !m_valid || r;
    any  = 1'b0;
    g    = m_ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = m_ptr + 2'(i);
      if (!any && v[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    rdy_m = 4'b0000;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    if (m_lock) begin
      g   = m_lock_ch;
      any = v[g];
      if (load) rdy_m[g] = 1'b1;
    end
`endif
    if (load && any) rdy_m[g] = 1'b1;
    check_output("in_ready", in_ready, rdy_m);
    if (tab) check_output("tab_in_ready", in_ready, t_rdy);
    if (m_valid) begin
      if (sb.size() == 0) begin
        check_output("sb_nonempty", 0, 1);
      end else begin
        b = sb[0];
        check_output("out_data", out_data, b.data);
        check_output("out_sel", out_sel, b.sel);
        check_output("out_last", out_last, b.last);
        if (r) void'(sb.pop_front());
      end
    end
    if (load) begin
      if (any) begin
        sb.push_back('{sel: g, data: in_data[g], last: l[g]});
        m_valid = 1'b1;
        m_ptr   = g;
        m_lock    = !l[g];
        m_lock_ch = g;
      end else begin
        m_valid = 1'b0;
      end
    end
`ifndef RR_STREAM_MUX_PKT_LOCK_EN
    m_lock = 1'b0;
`endif
    @(posedge clk);
    #1;
    check_output("out_valid", out_valid, m_valid);
    if (tab) begin
      check_output("tab_out_valid", out_valid, t_ov);
      if (t_ov) check_output("tab_out_sel", out_sel, t_sel);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i] = 8'hA0 + 8'(i);
    m_valid   = 1'b0;
    m_ptr     = 2'd3;
    m_lock    = 1'b0;
    m_lock_ch = 2'd0;

    // Fairness: all channels valid, grants 0,1,2,3,0, then drain.
    add_vec(4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA1, 8'hA2, 1'b0);
    // Single valid channel 2, data 55, four back-to-back beats.
    for (int i = 0; i < 4; i++)
      add_vec(4'h4, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA1, 8'h55, 1'b0);
    add_vec(4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA1, 8'h55, 1'b0);
    // Backpressure holding ch1 beat 11, then drain + ch3 load together.
    add_vec(4'h2, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 8'hA2, 1'b0);
    for (int i = 0; i < 3; i++)
      add_vec(4'h9, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11, 8'hA2, 1'b0);
    add_vec(4'h9, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h11, 8'hA2, 1'b0);
    add_vec(4'h9, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11, 8'hA2, 1'b0);
    add_vec(4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h11, 8'hA2, 1'b0);
    // Reset while a beat is held under backpressure; ch0 wins afterwards.
    add_vec(4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1, 8'hA2, 1'b1);
    add_vec(4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA1, 8'hA2, 1'b0);
    // Three-beat packet on ch1 with ch0/ch2 valid and a 2-cycle ch1 gap.
    add_vec(4'h7, 4'h0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 8'hA2, 1'b0);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    add_vec(4'h5, 4'h0, 1'b1, 4'b0010, 1'b0, 2'd0, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h5, 4'h0, 1'b1, 4'b0010, 1'b0, 2'd0, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h7, 4'h0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h7, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h5, 4'h5, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA1, 8'hA2, 1'b0);
`else
    add_vec(4'h5, 4'h0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h5, 4'h0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h7, 4'h0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h7, 4'h2, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA1, 8'hA2, 1'b0);
    add_vec(4'h5, 4'h5, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1, 8'hA2, 1'b0);
`endif
    add_vec(4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA1, 8'hA2, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    do_reset(4'h0, 1'b0);

    foreach (vecs[k]) begin
      in_data[1] = vecs[k].d1;
      in_data[2] = vecs[k].d2;
      if (vecs[k].rst) do_reset(vecs[k].v, 1'b0);
      apply_stimulus(vecs[k].v, vecs[k].l, vecs[k].r, 1'b1,
                     vecs[k].rdy, vecs[k].ov, vecs[k].sel);
    end

    // Random traffic with random backpressure, checked by the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
      apply_stimulus(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                     1'b0, 4'b0000, 1'b0, 2'd0);
    end
    repeat (3) apply_stimulus(4'h0, 4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0);
    check_output("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
